// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MULT/DIV/MADD/MSUB sequencer producing the HI/LO pair.
// Holds EXE via stall, pulses finish for one cycle when res_hi/res_lo are valid.
module muldiv_ctrl #(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic        flush,
    output logic        stall,
    output logic        finish,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam int PD = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

    logic [2:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [31:0] rem_q, rem_d, quot_q, quot_d;
    logic [63:0] res_q, res_d;
    logic [63:0] pipe_q [PD];
    logic [63:0] pipe_d [PD];
    logic        accept, busy, signed_op, a_neg, b_neg;
    logic [63:0] a64, b64, prod, acc, mul_res, mul_tail, div_res;
    logic [31:0] b_mag, q_fix, r_fix;
    logic [32:0] rem_sh, diff;

    always_comb begin
        accept    = start & (state_q == S_IDLE) & ~flush;
        busy      = (state_q == S_MUL) | (state_q == S_DIV) | (state_q == S_FIX);
        signed_op = ~op_q[0];
        a_neg     = signed_op & a_q[31];
        b_neg     = signed_op & b_q[31];
        a64       = {{32{a_neg}}, a_q};
        b64       = {{32{b_neg}}, b_q};
        prod      = a64 * b64;
        acc       = {hi_q, lo_q};
        mul_res   = (op_q[2:1] == 2'b00) ? prod :
                    (op_q[2:1] == 2'b10) ? acc + prod : acc - prod;
        // the product is retimed through PD registers; the last stage lands in res_q
        mul_tail  = (MUL_LAT == 1) ? mul_res : pipe_q[PD-1];
        b_mag     = b_neg ? -b_q : b_q;
        rem_sh    = {rem_q, quot_q[31]};
        diff      = rem_sh - {1'b0, b_mag};
        q_fix     = (a_neg ^ b_neg) ? -quot_q : quot_q;
        r_fix     = a_neg ? -rem_q : rem_q;
        div_res   = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {r_fix, q_fix};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        res_d   = res_q;
        pipe_d[0] = mul_res;
        for (int i = 1; i < PD; i++) pipe_d[i] = pipe_q[i-1];
        if (accept) begin
            op_d    = op;
            a_d     = src_a;
            b_d     = src_b;
            hi_d    = hi_in;
            lo_d    = lo_in;
            quot_d  = (~op[0] & src_a[31]) ? -src_a : src_a;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = (op[2:1] == 2'b01) ? S_DIV : S_MUL;
        end else if (busy & flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (state_q == S_MUL) begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(MUL_LAT - 1)) begin
                state_d = S_DONE;
                cnt_d   = '0;
                res_d   = mul_tail;
            end
        end else if (state_q == S_DIV) begin
            // restoring step: keep the trial subtraction only if it did not borrow
            rem_d  = diff[32] ? rem_sh[31:0] : diff[31:0];
            quot_d = {quot_q[30:0], ~diff[32]};
            cnt_d  = cnt_q + 6'd1;
            if (cnt_q == 6'(DIV_ITER - 1)) begin
                state_d = S_FIX;
                cnt_d   = '0;
            end
        end else if (state_q == S_FIX) begin
            state_d = S_DONE;
            res_d   = div_res;
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            res_q   <= '0;
            for (int i = 0; i < PD; i++) pipe_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            res_q   <= res_d;
            for (int i = 0; i < PD; i++) pipe_q[i] <= pipe_d[i];
        end
    end

    assign stall  = accept | busy;
    assign finish = (state_q == S_DONE) & ~flush;
    assign res_hi = res_q[63:32];
    assign res_lo = res_q[31:0];
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: randomized and directed checks of muldiv_ctrl against an arithmetic model.
module tb_muldiv_ctrl;
    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] src_a, src_b, hi_in, lo_in;
    logic        stall, finish;
    logic [31:0] res_hi, res_lo;
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .hi_in(hi_in), .lo_in(lo_in), .flush(flush), .stall(stall), .finish(finish),
        .res_hi(res_hi), .res_lo(res_lo)
    );

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, b, h, l);
        logic [63:0] x, y, q, r, p;
        logic sgn;
        sgn = ~o[0];
        x = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        y = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        if (o == 3'd2 || o == 3'd3) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
            return {r[31:0], q[31:0]};
        end
        p = x * y;
        if (o == 3'd0 || o == 3'd1) return p;
        if (o == 3'd4 || o == 3'd5) return {h, l} + p;
        return {h, l} - p;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return $urandom_range(0, 20);
            default: return $urandom();
        endcase
    endfunction

    // caller is positioned at a negedge; the op is accepted at the next posedge
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, b, h, l, input string name);
        logic [63:0] exp;
        int lat, n;
        bit stall_ok;
        exp = model(o, a, b, h, l);
        lat = (o[2:1] == 2'b01) ? 34 : MUL_LAT + 1;
        op = o; src_a = a; src_b = b; hi_in = h; lo_in = l; start = 1'b1;
        #1;
        total++;
        if (stall !== 1'b1) $display("FAIL %s accept_stall: got %b want 1", name, stall);
        else passed++;
        n = 0;
        stall_ok = 1'b1;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (finish === 1'b1) break;
            if (stall !== 1'b1) stall_ok = 1'b0;
        end
        total++;
        if (n != lat) $display("FAIL %s latency: got %0d want %0d", name, n, lat);
        else passed++;
        total++;
        if ({res_hi, res_lo} !== exp)
            $display("FAIL %s result: got %h_%h want %h_%h (op=%0d a=%h b=%h hi=%h lo=%h)",
                     name, res_hi, res_lo, exp[63:32], exp[31:0], o, a, b, h, l);
        else passed++;
        total++;
        if (stall !== 1'b0) $display("FAIL %s done_stall: got %b want 0", name, stall);
        else passed++;
        total++;
        if (!stall_ok) $display("FAIL %s busy_stall: got 0 want 1 while running", name);
        else passed++;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (finish !== 1'b0) $display("FAIL %s pulse_width: got %b want 0", name, finish);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0;
        src_a = '0; src_b = '0; hi_in = '0; lo_in = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({stall, finish} !== 2'b00) $display("FAIL reset_ctl: got %b want 00", {stall, finish});
        else passed++;
        total++;
        if ({res_hi, res_lo} !== 64'd0) $display("FAIL reset_res: got %h_%h want 0", res_hi, res_lo);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(3'd0, -32'sd3, 32'd5, 32'd0, 32'd0, "mult_neg");
        total++;
        if ({res_hi, res_lo} !== 64'hFFFF_FFFF_FFFF_FFF1)
            $display("FAIL mult_const: got %h_%h want ffffffff_fffffff1", res_hi, res_lo);
        else passed++;
        run_op(3'd3, 32'd100, 32'd7, 32'd0, 32'd0, "divu_100_7");
        total++;
        if ({res_hi, res_lo} !== {32'd2, 32'd14})
            $display("FAIL divu_const: got %h_%h want 00000002_0000000e", res_hi, res_lo);
        else passed++;
        run_op(3'd2, -32'sd7, 32'd2, 32'd0, 32'd0, "div_neg7_2");
        run_op(3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, "maddu_carry");
        run_op(3'd6, 32'd1, 32'd1, 32'd0, 32'd0, "msub_wrap");
        run_op(3'd2, 32'h1234_5678, 32'd0, 32'd0, 32'd0, "div_by_zero");
        total++;
        if ({res_hi, res_lo} !== 64'h1234_5678_FFFF_FFFF)
            $display("FAIL divz_const: got %h_%h want 12345678_ffffffff", res_hi, res_lo);
        else passed++;
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, "div_overflow");
        run_op(3'd3, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, "divu_by_zero");
        run_op(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h2, "msubu_big");
    endtask

    task automatic test_random_back_to_back();
        for (int k = 0; k < 40; k++)
            run_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom(), $urandom(), "random");
    endtask

    task automatic test_flush_div();
        bit early;
        early = 1'b0;
        op = 3'd3; src_a = 32'd5000; src_b = 32'd9; start = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (finish !== 1'b0) early = 1'b1;
        end
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        total++;
        if ({stall, finish} !== 2'b00 || early)
            $display("FAIL flush_div_abort: got stall=%b finish=%b early=%b want 0 0 0", stall, finish, early);
        else passed++;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0, "mult_after_flush");
        early = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (finish !== 1'b0 || stall !== 1'b0) early = 1'b1;
        end
        total++;
        if (early) $display("FAIL flush_no_late_finish: got activity want none");
        else passed++;
    endtask

    task automatic test_flush_done();
        op = 3'd1; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
        repeat (MUL_LAT + 1) @(negedge clk);
        flush = 1'b1;
        #1;
        total++;
        if (finish !== 1'b0) $display("FAIL flush_done_suppress: got %b want 0", finish);
        else passed++;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        total++;
        if ({stall, finish} !== 2'b00) $display("FAIL flush_done_after: got %b want 00", {stall, finish});
        else passed++;
    endtask

    task automatic test_rst_mid();
        bit bad;
        op = 3'd2; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({stall, finish} !== 2'b00 || {res_hi, res_lo} !== 64'd0)
            $display("FAIL rst_mid: got stall=%b finish=%b res=%h_%h want 0 0 0", stall, finish, res_hi, res_lo);
        else passed++;
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (finish !== 1'b0 || stall !== 1'b0) bad = 1'b1;
        end
        total++;
        if (bad) $display("FAIL rst_mid_quiet: got activity want none");
        else passed++;
    endtask

    task automatic test_start_flush();
        bit bad;
        bad = 1'b0;
        op = 3'd0; src_a = 32'd9; src_b = 32'd9; start = 1'b1; flush = 1'b1;
        #1;
        if (stall !== 1'b0) bad = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (stall !== 1'b0 || finish !== 1'b0) bad = 1'b1;
        end
        start = 1'b0; flush = 1'b0;
        total++;
        if (bad) $display("FAIL start_flush: got accepted want ignored");
        else passed++;
        @(negedge clk);
        run_op(3'd4, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd5, "madd_after_start_flush");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_back_to_back();
        test_flush_div();
        test_flush_done();
        test_rst_mid();
        test_start_flush();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
